// File: rtl/spi_pkg.sv
// Shared types for the parametrised SPI master.
//   spi_state_t : transfer phases (IDLE, LEAD, TRANSFER, TRAIL)
//   spi_mode_t  : per-transfer mode bits captured when a transfer is accepted
//   spi_cs_width: width of the chip-select index port (at least 1 bit)
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LEAD     = 2'd1,
    TRANSFER = 2'd2,
    TRAIL    = 2'd3
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

  function automatic int spi_cs_width(input int num_cs);
    return (num_cs > 1) ? $clog2(num_cs) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator for the SPI master.
//   i_clk   : system clock
//   i_reset : synchronous active-high reset
//   i_en    : count while high; count is cleared while low
//   o_tick  : one-cycle strobe every CLK_DIV enabled cycles
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  output logic o_tick
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // The tick marks the last cycle of each half-period, so the first tick
  // after enable arrives in the CLK_DIV-th enabled cycle.
  assign o_tick = i_en && (r_cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset || !i_en || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master with start/busy/done handshake.
//   mclk, reset           : system clock, synchronous active-high reset
//   start                 : transfer request, accepted while busy is low
//   data_in, cpol, cpha,
//   lsb_first, cs_sel     : transfer settings, captured on accept
//   miso / mosi, sclk     : serial interface (sclk is a flop output)
//   cs_n                  : active-low chip selects, one per slave
//   busy                  : high from accept until the transfer ends
//   done, data_out        : one-cycle completion pulse and received word
//   dbg_state             : current transfer phase
// Handshake: a request is taken on any clock edge where start=1 and busy=0;
// start while busy is dropped. done pulses in the cycle busy falls, and a
// start in that same cycle begins the next transfer immediately.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2,
  parameter int NUM_CS  = 1,
  localparam int CS_W   = spi_cs_width(NUM_CS)
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              miso,
  output logic              mosi,
  output logic              sclk,
  output logic [NUM_CS-1:0] cs_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output spi_state_t        dbg_state
);

  localparam int BIT_W = $clog2(2 * DATA_W + 1);
  localparam logic [BIT_W-1:0] LAST_TOGGLE = BIT_W'(2 * DATA_W);

  spi_state_t        r_state;
  spi_state_t        w_next_state;
  spi_mode_t         r_mode;
  logic              r_mode_valid;
  logic [CS_W-1:0]   r_cs_sel;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_data_out;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              r_sclk;
  logic              r_mosi;
  logic              r_done;

  logic              w_busy;
  logic              w_tick;
  logic              w_accept;
  logic              w_toggle;
  logic              w_leading;
  logic              w_last_toggle;
  logic              w_end;
  logic [BIT_W-1:0]  w_bit_cnt_nxt;
  logic [DATA_W-1:0] w_tx_ordered;

  function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = v[DATA_W-1-i];
    end
    return r;
  endfunction

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .i_clk  (mclk),
    .i_reset(reset),
    .i_en   (w_busy),
    .o_tick (w_tick)
  );

  assign w_accept      = start && (r_state == IDLE);
  assign w_toggle      = w_tick && (r_state == TRANSFER);
  assign w_end         = w_tick && (r_state == TRAIL);
  assign w_bit_cnt_nxt = r_bit_cnt + 1'b1;
  // Odd toggle numbers are leading edges.
  assign w_leading     = w_bit_cnt_nxt[0];
  assign w_last_toggle = (w_bit_cnt_nxt == LAST_TOGGLE);
  // Storing the word pre-reversed lets the shifter always emit from the MSB.
  assign w_tx_ordered  = lsb_first ? bit_reverse(data_in) : data_in;

  always_ff @(posedge mclk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_busy       = (r_state != IDLE);
    cs_n         = '1;
    unique case (r_state)
      IDLE:     if (w_accept) w_next_state = LEAD;
      LEAD:     if (w_tick) w_next_state = TRANSFER;
      TRANSFER: if (w_toggle && w_last_toggle) w_next_state = TRAIL;
      TRAIL:    if (w_tick) w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
    // An out-of-range index matches no line, so nothing is selected.
    for (int i = 0; i < NUM_CS; i++) begin
      if (w_busy && (r_cs_sel == CS_W'(i))) begin
        cs_n[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      r_mode       <= '0;
      r_mode_valid <= 1'b0;
      r_cs_sel     <= '0;
      r_tx         <= '0;
      r_rx         <= '0;
      r_data_out   <= '0;
      r_bit_cnt    <= '0;
      r_sclk       <= 1'b0;
      r_mosi       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_accept) begin
        r_mode       <= {cpol, cpha, lsb_first};
        r_mode_valid <= 1'b1;
        r_cs_sel     <= cs_sel;
        r_tx         <= w_tx_ordered;
        r_mosi       <= w_tx_ordered[DATA_W-1];
        r_sclk       <= cpol;
        r_bit_cnt    <= '0;
      end else if (r_state == IDLE) begin
        // Until a mode has been captured, follow the live cpol input.
        r_sclk <= r_mode_valid ? r_mode.cpol : cpol;
      end

      if (w_toggle) begin
        r_sclk    <= ~r_sclk;
        r_bit_cnt <= w_bit_cnt_nxt;
        if (w_leading) begin
          if (r_mode.cpha) begin
            r_mosi <= r_tx[DATA_W-1];
            r_tx   <= r_tx << 1;
          end else begin
            r_rx <= {r_rx[DATA_W-2:0], miso};
          end
        end else begin
          if (r_mode.cpha) begin
            r_rx <= {r_rx[DATA_W-2:0], miso};
          end else if (!w_last_toggle) begin
            // First bit already sits on mosi from accept; next one is at W-2.
            r_mosi <= r_tx[DATA_W-2];
            r_tx   <= r_tx << 1;
          end
        end
      end

      if (w_end) begin
        r_done     <= 1'b1;
        r_data_out <= r_mode.lsb_first ? bit_reverse(r_rx) : r_rx;
      end
    end
  end

  assign busy      = w_busy;
  assign sclk      = r_sclk;
  assign mosi      = r_mosi;
  assign done      = r_done;
  assign data_out  = r_data_out;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_master_param.sv
`timescale 1ns/1ps
module tb_spi_master_param;
  import spi_pkg::*;

  localparam int AW = 8;
  localparam int AD = 2;
  localparam int BW = 16;
  localparam int BD = 3;
  localparam int BN = 4;
  localparam int CW = 2;
  localparam int CD = 1;
  localparam int CN = 5;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  logic mclk  = 1'b0;
  logic reset = 1'b1;
  always #5 mclk = ~mclk;

  // ---------------- instance A: defaults ----------------
  logic          start_a   = 1'b0;
  logic [AW-1:0] data_in_a = '0;
  logic          cpol_a    = 1'b0;
  logic          cpha_a    = 1'b0;
  logic          lsb_a     = 1'b0;
  logic [0:0]    cs_sel_a  = '0;
  logic          loop_a    = 1'b1;
  logic          slave_a   = 1'b0;
  logic          miso_a, mosi_a, sclk_a, busy_a, done_a;
  logic [0:0]    cs_n_a;
  logic [AW-1:0] data_out_a;
  spi_state_t    dbg_a;
  assign miso_a = loop_a ? mosi_a : slave_a;

  spi_master_param #(.DATA_W(AW), .CLK_DIV(AD), .NUM_CS(1)) u_dut_a (
    .mclk(mclk), .reset(reset), .start(start_a), .data_in(data_in_a),
    .cpol(cpol_a), .cpha(cpha_a), .lsb_first(lsb_a), .cs_sel(cs_sel_a),
    .miso(miso_a), .mosi(mosi_a), .sclk(sclk_a), .cs_n(cs_n_a),
    .busy(busy_a), .done(done_a), .data_out(data_out_a), .dbg_state(dbg_a)
  );

  // ---------------- instance B: wide word, slow clock, 4 slaves ----------------
  logic          start_b   = 1'b0;
  logic [BW-1:0] data_in_b = '0;
  logic          cpol_b    = 1'b0;
  logic          cpha_b    = 1'b0;
  logic          lsb_b     = 1'b0;
  logic [1:0]    cs_sel_b  = '0;
  logic          miso_b, mosi_b, sclk_b, busy_b, done_b;
  logic [BN-1:0] cs_n_b;
  logic [BW-1:0] data_out_b;
  spi_state_t    dbg_b;
  assign miso_b = mosi_b;

  spi_master_param #(.DATA_W(BW), .CLK_DIV(BD), .NUM_CS(BN)) u_dut_b (
    .mclk(mclk), .reset(reset), .start(start_b), .data_in(data_in_b),
    .cpol(cpol_b), .cpha(cpha_b), .lsb_first(lsb_b), .cs_sel(cs_sel_b),
    .miso(miso_b), .mosi(mosi_b), .sclk(sclk_b), .cs_n(cs_n_b),
    .busy(busy_b), .done(done_b), .data_out(data_out_b), .dbg_state(dbg_b)
  );

  // ---------------- instance C: minimum word/divider, 5 slaves ----------------
  logic          start_c   = 1'b0;
  logic [CW-1:0] data_in_c = '0;
  logic          cpol_c    = 1'b0;
  logic          cpha_c    = 1'b0;
  logic          lsb_c     = 1'b0;
  logic [2:0]    cs_sel_c  = '0;
  logic          miso_c, mosi_c, sclk_c, busy_c, done_c;
  logic [CN-1:0] cs_n_c;
  logic [CW-1:0] data_out_c;
  spi_state_t    dbg_c;
  assign miso_c = mosi_c;

  spi_master_param #(.DATA_W(CW), .CLK_DIV(CD), .NUM_CS(CN)) u_dut_c (
    .mclk(mclk), .reset(reset), .start(start_c), .data_in(data_in_c),
    .cpol(cpol_c), .cpha(cpha_c), .lsb_first(lsb_c), .cs_sel(cs_sel_c),
    .miso(miso_c), .mosi(mosi_c), .sclk(sclk_c), .cs_n(cs_n_c),
    .busy(busy_c), .done(done_c), .data_out(data_out_c), .dbg_state(dbg_c)
  );

  // ---------------- driver + reference model for instance A ----------------
  // The model is a plain SPI slave: it presents the word bit by bit on the
  // slave-drive edges and records what mosi shows on the master-sample edges.
  task automatic run_xfer_a(input logic [AW-1:0] tx, input logic pol, input logic pha,
                            input logic lsb, input logic loop, input logic [AW-1:0] sw,
                            input string name);
    logic [0:0] exp_q[$];
    logic [AW-1:0] exp_rx;
    int cyc, edges, rises, done_cyc, idx;
    logic prev, leading;
    for (int i = 0; i < AW; i++) exp_q.push_back(lsb ? tx[i] : tx[AW-1-i]);
    exp_rx  = loop ? tx : sw;
    loop_a  = loop;
    slave_a = lsb ? sw[0] : sw[AW-1];
    @(negedge mclk);
    data_in_a = tx; cpol_a = pol; cpha_a = pha; lsb_a = lsb; start_a = 1'b1;
    @(negedge mclk);
    start_a = 1'b0; cyc = 1;
    data_in_a = 8'($urandom); cpol_a = ~pol; cpha_a = ~pha; lsb_a = ~lsb;
    total++; if ({busy_a, cs_n_a, sclk_a} !== {1'b1, 1'b0, pol}) begin
      bad++; $display("FAIL %s accept: busy/cs_n/sclk got %b%b%b want %b%b%b", name, busy_a, cs_n_a, sclk_a, 1'b1, 1'b0, pol);
    end
    if (!pha) begin
      total++; if (mosi_a !== exp_q[0]) begin
        bad++; $display("FAIL %s first mosi: got %b want %b", name, mosi_a, exp_q[0]);
      end
    end
    prev = sclk_a; edges = 0; rises = 0; done_cyc = 0;
    while (done_cyc == 0 && cyc < 200) begin
      @(negedge mclk); cyc++;
      if (done_a) done_cyc = cyc;
      if (sclk_a !== prev) begin
        edges++; prev = sclk_a;
        if (sclk_a) rises++;
        leading = edges[0];
        if (leading != pha) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL %s extra sample edge %0d: got mosi %b want none", name, edges, mosi_a);
          end else if (mosi_a !== exp_q[0]) begin
            bad++; $display("FAIL %s mosi edge %0d: got %b want %b", name, edges, mosi_a, exp_q[0]);
          end
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (pha && leading) begin
          idx = (edges - 1) / 2; slave_a = lsb ? sw[idx] : sw[AW-1-idx];
        end else if (!pha && !leading && (edges / 2) < AW) begin
          idx = edges / 2; slave_a = lsb ? sw[idx] : sw[AW-1-idx];
        end
      end
    end
    total++; if (done_cyc != 1 + AD * (2 * AW + 2)) begin
      bad++; $display("FAIL %s done latency: got %0d want %0d", name, done_cyc, 1 + AD * (2 * AW + 2));
    end
    total++; if (edges != 2 * AW || rises != AW) begin
      bad++; $display("FAIL %s sclk edges: got %0d/%0d rising want %0d/%0d", name, edges, rises, 2 * AW, AW);
    end
    total++; if (exp_q.size() != 0) begin
      bad++; $display("FAIL %s mosi bits unsampled: got %0d left want 0", name, exp_q.size());
    end
    total++; if (data_out_a !== exp_rx) begin
      bad++; $display("FAIL %s data_out: got %h want %h", name, data_out_a, exp_rx);
    end
    total++; if ({busy_a, cs_n_a, sclk_a} !== {1'b0, 1'b1, pol}) begin
      bad++; $display("FAIL %s end: busy/cs_n/sclk got %b%b%b want %b%b%b", name, busy_a, cs_n_a, sclk_a, 1'b0, 1'b1, pol);
    end
    @(negedge mclk);
    total++; if ({done_a, sclk_a} !== {1'b0, pol}) begin
      bad++; $display("FAIL %s after done: done/sclk got %b%b want %b%b", name, done_a, sclk_a, 1'b0, pol);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge mclk);
    total++; if ({mosi_a, sclk_a, cs_n_a, busy_a, done_a, data_out_a} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      bad++; $display("FAIL reset A outputs: got %b%b%b%b%b %h want 00100 00", mosi_a, sclk_a, cs_n_a, busy_a, done_a, data_out_a);
    end
    total++; if ({cs_n_b, busy_b, done_b, data_out_b} !== {4'hF, 1'b0, 1'b0, 16'h0000}) begin
      bad++; $display("FAIL reset B outputs: got %h %b%b %h want f 00 0000", cs_n_b, busy_b, done_b, data_out_b);
    end
    total++; if ({cs_n_c, busy_c, done_c, data_out_c} !== {5'h1F, 1'b0, 1'b0, 2'b00}) begin
      bad++; $display("FAIL reset C outputs: got %h %b%b %b want 1f 00 00", cs_n_c, busy_c, done_c, data_out_c);
    end
    total++; if ({dbg_a, dbg_b, dbg_c} !== {IDLE, IDLE, IDLE}) begin
      bad++; $display("FAIL reset state: got %0d %0d %0d want 0 0 0", dbg_a, dbg_b, dbg_c);
    end
    reset = 1'b0; cpol_a = 1'b1;
    repeat (2) @(negedge mclk);
    total++; if (sclk_a !== 1'b1) begin
      bad++; $display("FAIL idle sclk follows cpol=1: got %b want 1", sclk_a);
    end
    cpol_a = 1'b0;
    repeat (2) @(negedge mclk);
    total++; if (sclk_a !== 1'b0) begin
      bad++; $display("FAIL idle sclk follows cpol=0: got %b want 0", sclk_a);
    end
  endtask

  task automatic test_loopback_mode0();
    run_xfer_a(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, "loop_mode0");
  endtask

  task automatic test_slave_mode3();
    run_xfer_a(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 8'hC3, "slave_mode3");
  endtask

  task automatic test_handshake();
    int cyc;
    int done_q[$];
    int d0, d1;
    logic [AW-1:0] rx0, rx1;
    logic [2:0] cs_win;
    logic busy_after;
    rx0 = '0; rx1 = '0; cs_win = '0; busy_after = 1'b0;
    loop_a = 1'b1;
    @(negedge mclk);
    data_in_a = 8'h5A; cpol_a = 1'b0; cpha_a = 1'b0; lsb_a = 1'b0; start_a = 1'b1;
    @(negedge mclk);
    start_a = 1'b0; cyc = 1;
    while (cyc < 90) begin
      @(negedge mclk); cyc++;
      if (done_a) begin
        done_q.push_back(cyc);
        if (done_q.size() == 1) rx0 = data_out_a; else rx1 = data_out_a;
      end
      if (cyc >= 36 && cyc <= 38) cs_win[cyc-36] = cs_n_a[0];
      if (cyc == 38) busy_after = busy_a;
      if (cyc == 10) begin start_a = 1'b1; data_in_a = 8'hFF; end
      if (cyc == 11) start_a = 1'b0;
      if (cyc == 30) begin start_a = 1'b1; data_in_a = 8'h81; end
      if (cyc == 38) start_a = 1'b0;
    end
    d0 = (done_q.size() > 0) ? done_q[0] : -1;
    d1 = (done_q.size() > 1) ? done_q[1] : -1;
    total++; if (done_q.size() != 2 || d0 != 37 || d1 != 74) begin
      bad++; $display("FAIL handshake done cycles: got n=%0d %0d %0d want n=2 37 74", done_q.size(), d0, d1);
    end
    total++; if (rx0 !== 8'h5A) begin
      bad++; $display("FAIL handshake first word: got %h want 5a", rx0);
    end
    total++; if (rx1 !== 8'h81) begin
      bad++; $display("FAIL handshake second word: got %h want 81", rx1);
    end
    total++; if ({busy_after, cs_win} !== 4'b1010) begin
      bad++; $display("FAIL handshake cs gap: got busy=%b cs_n(36..38)=%b want busy=1 cs_n=010", busy_after, cs_win);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    loop_a = 1'b1;
    @(negedge mclk);
    data_in_a = 8'hA5; cpol_a = 1'b0; cpha_a = 1'b0; lsb_a = 1'b0; start_a = 1'b1;
    @(negedge mclk);
    start_a = 1'b0;
    repeat (19) @(negedge mclk);
    cpol_a = 1'b1; reset = 1'b1;
    @(negedge mclk);
    total++; if ({cs_n_a, sclk_a, busy_a, done_a, data_out_a} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      bad++; $display("FAIL reset_mid outputs: got %b%b%b%b %h want 1000 00", cs_n_a, sclk_a, busy_a, done_a, data_out_a);
    end
    reset = 1'b0;
    @(negedge mclk);
    total++; if (sclk_a !== 1'b1) begin
      bad++; $display("FAIL reset_mid idle sclk from live cpol: got %b want 1", sclk_a);
    end
    cpol_a = 1'b0; pulses = 0;
    repeat (50) begin
      @(negedge mclk);
      if (done_a || busy_a) pulses++;
    end
    total++; if (pulses != 0) begin
      bad++; $display("FAIL reset_mid activity after reset: got %0d cycles want 0", pulses);
    end
    run_xfer_a(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_xfer_a(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                 $sformatf("rand%0d", i));
    end
  endtask

  task automatic run_xfer_b(input logic [BW-1:0] tx, input logic [1:0] sel, input logic pha, input string name);
    logic [BN-1:0] exp_cs;
    int cyc, done_cyc, edges, rises, first_edge, last_edge, gap_err, cs_err;
    logic prev;
    exp_cs = ~(BN'(1) << sel);
    @(negedge mclk);
    data_in_b = tx; cs_sel_b = sel; cpha_b = pha; start_b = 1'b1;
    @(negedge mclk);
    start_b = 1'b0; data_in_b = 16'($urandom); cs_sel_b = sel + 2'd1; cyc = 1;
    cs_err = ({busy_b, cs_n_b} !== {1'b1, exp_cs}) ? 1 : 0;
    prev = sclk_b; edges = 0; rises = 0; done_cyc = 0; first_edge = 0; last_edge = 0; gap_err = 0;
    while (done_cyc == 0 && cyc < 400) begin
      @(negedge mclk); cyc++;
      if (done_b) done_cyc = cyc;
      else if ({busy_b, cs_n_b} !== {1'b1, exp_cs}) cs_err++;
      if (sclk_b !== prev) begin
        edges++; prev = sclk_b;
        if (sclk_b) rises++;
        if (edges == 1) first_edge = cyc;
        else if (cyc - last_edge != BD) gap_err++;
        last_edge = cyc;
      end
    end
    total++; if (cs_err != 0) begin
      bad++; $display("FAIL %s cs_n/busy during transfer: got %0d bad cycles (last cs_n=%h) want 0 (cs_n=%h)", name, cs_err, cs_n_b, exp_cs);
    end
    total++; if (first_edge != 1 + 2 * BD || gap_err != 0) begin
      bad++; $display("FAIL %s sclk timing: got first=%0d gap errors=%0d want first=%0d gaps=0", name, first_edge, gap_err, 1 + 2 * BD);
    end
    total++; if (edges != 2 * BW || rises != BW) begin
      bad++; $display("FAIL %s sclk edges: got %0d/%0d want %0d/%0d", name, edges, rises, 2 * BW, BW);
    end
    total++; if (done_cyc != 1 + BD * (2 * BW + 2)) begin
      bad++; $display("FAIL %s done latency: got %0d want %0d", name, done_cyc, 1 + BD * (2 * BW + 2));
    end
    total++; if ({data_out_b, cs_n_b} !== {tx, 4'hF}) begin
      bad++; $display("FAIL %s end: data_out/cs_n got %h/%h want %h/f", name, data_out_b, cs_n_b, tx);
    end
    @(negedge mclk);
  endtask

  task automatic test_param_sweep();
    run_xfer_b(16'hBEEF, 2'd2, 1'b0, "sweep_cs2");
    run_xfer_b(16'($urandom), 2'd3, 1'b1, "sweep_cs3_cpha1");
  endtask

  task automatic run_xfer_c(input logic [CW-1:0] tx, input logic [2:0] sel, input string name);
    logic [CN-1:0] exp_cs;
    int cyc, done_cyc, cs_err;
    exp_cs = (int'(sel) < CN) ? ~(CN'(1) << sel) : {CN{1'b1}};
    @(negedge mclk);
    data_in_c = tx; cs_sel_c = sel; start_c = 1'b1;
    @(negedge mclk);
    start_c = 1'b0; cs_sel_c = 3'($urandom); cyc = 1;
    cs_err = ({busy_c, cs_n_c} !== {1'b1, exp_cs}) ? 1 : 0;
    done_cyc = 0;
    while (done_cyc == 0 && cyc < 50) begin
      @(negedge mclk); cyc++;
      if (done_c) done_cyc = cyc;
      else if ({busy_c, cs_n_c} !== {1'b1, exp_cs}) cs_err++;
    end
    total++; if (cs_err != 0) begin
      bad++; $display("FAIL %s cs_n/busy: got %0d bad cycles (cs_n=%h) want 0 (cs_n=%h)", name, cs_err, cs_n_c, exp_cs);
    end
    total++; if (done_cyc != 1 + CD * (2 * CW + 2)) begin
      bad++; $display("FAIL %s done latency: got %0d want %0d", name, done_cyc, 1 + CD * (2 * CW + 2));
    end
    total++; if ({data_out_c, cs_n_c} !== {tx, 5'h1F}) begin
      bad++; $display("FAIL %s end: data_out/cs_n got %b/%h want %b/1f", name, data_out_c, cs_n_c, tx);
    end
    @(negedge mclk);
  endtask

  task automatic test_cs_out_of_range();
    run_xfer_c(2'b10, 3'd5, "cs_sel5");
    run_xfer_c(2'b01, 3'd7, "cs_sel7");
    run_xfer_c(2'b11, 3'd4, "cs_sel4");
    run_xfer_c(2'($urandom), 3'd0, "cs_sel0");
  endtask

  initial begin
    test_reset();
    test_loopback_mode0();
    test_slave_mode3();
    test_handshake();
    test_reset_mid();
    test_random();
    test_param_sweep();
    test_cs_out_of_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
